i2c_slave_param: RTL and testbench

I2C_SLAVE_PARAM -- requirements
Module: i2c_slave_param

---
 rtl/i2c_slave_param.sv | 176 +++++++++++++++++
 tb/tb_i2c_slave_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_param.sv
// i2c_slave_param: I2C slave with parameterised address, shift-in write buffer and indexed read buffer
`timescale 1ns/1ps
module i2c_slave_param #(
  parameter logic [6:0] ADDRESS   = 7'h6A,
  parameter int         NBYTES    = 33,
  parameter int         TX_NBYTES = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        scl,
  inout  wire                         sda,
  input  logic [8*TX_NBYTES-1:0]      data_in,
  output logic [8*NBYTES-1:0]         data_out,
  output logic [$clog2(NBYTES+1)-1:0] byte_count,
  output logic                        busy,
  output logic                        rx_done,
  output logic                        tx_done,
  output logic                        overflow
);
  localparam int CW = $clog2(NBYTES+1);
  localparam int TW = TX_NBYTES > 1 ? $clog2(TX_NBYTES) : 1;
  localparam logic [CW-1:0] FULL = CW'(NBYTES);
  localparam logic [TW-1:0] LAST = TW'(TX_NBYTES-1);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [1:0] scl_ff, sda_ff;
  logic scl_p, sda_p, scl_s, sda_s, start, stop, rise, fall;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, tx_byte, tx_next;
  logic [TW-1:0] idx, idx_n, idx_next;
  logic rw, rw_n, wr, wr_n, ack, ack_n, sda_oe, sda_oe_n;
  logic [8*NBYTES-1:0] data_out_n, data_sh;
  logic [CW-1:0] byte_count_n;
  logic busy_n, rx_done_n, tx_done_n, overflow_n;
  assign scl_s = scl_ff[1];
  assign sda_s = sda_ff[1];
  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop  = scl_s & scl_p & ~sda_p & sda_s;
  assign rise  = scl_s & ~scl_p;
  assign fall  = ~scl_s & scl_p;
  assign idx_next = idx == LAST ? '0 : idx + 1'b1;
  assign tx_byte = data_in[8*TX_NBYTES-1-8*int'(idx) -: 8];
  assign tx_next = data_in[8*TX_NBYTES-1-8*int'(idx_next) -: 8];
  assign sda = sda_oe ? 1'b0 : 1'bz;
  if (NBYTES > 1) begin : g_sh
    assign data_sh = {data_out[8*NBYTES-9:0], shift};
  end else begin : g_one
    assign data_sh = shift;
  end
  // bit_cnt counts SCL rising edges, so the falling edge that closes START is never mistaken for a bit
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shift_n = shift;
    idx_n = idx;
    rw_n = rw;
    wr_n = wr;
    ack_n = ack;
    sda_oe_n = sda_oe;
    data_out_n = data_out;
    byte_count_n = byte_count;
    busy_n = busy;
    overflow_n = overflow;
    rx_done_n = 1'b0;
    tx_done_n = 1'b0;
    if (start) begin
      state_n = ADDR;
      bit_cnt_n = '0;
      byte_count_n = '0;
      data_out_n = '0;
      overflow_n = 1'b0;
      busy_n = 1'b1;
      sda_oe_n = 1'b0;
      wr_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      sda_oe_n = 1'b0;
      busy_n = 1'b0;
      rx_done_n = busy & wr & (byte_count != '0);
    end else if (rise) begin
      if (state == ADDR || state == WRITE || state == READ) begin
        shift_n = {shift[6:0], sda_s};
        bit_cnt_n = bit_cnt + 1'b1;
      end
      ack_n = state == READ_ACK ? sda_s : ack;
    end else if (fall) begin
      case (state)
        ADDR: if (bit_cnt == 4'd8) begin
          bit_cnt_n = '0;
          rw_n = shift[0];
          state_n = shift[7:1] == ADDRESS ? ADDR_ACK : WAIT_STOP;
          sda_oe_n = shift[7:1] == ADDRESS;
        end
        ADDR_ACK: begin
          bit_cnt_n = '0;
          state_n = rw ? READ : WRITE;
          wr_n = ~rw;
          idx_n = '0;
          sda_oe_n = rw & ~data_in[8*TX_NBYTES-1];
        end
        WRITE: if (bit_cnt == 4'd8) begin
          bit_cnt_n = '0;
          if (byte_count != FULL) begin
            data_out_n = data_sh;
            byte_count_n = byte_count + 1'b1;
            state_n = WRITE_ACK;
            sda_oe_n = 1'b1;
          end else begin
            overflow_n = 1'b1;
            state_n = WAIT_STOP;
            sda_oe_n = 1'b0;
          end
        end
        WRITE_ACK: begin
          state_n = WRITE;
          sda_oe_n = 1'b0;
        end
        READ: if (bit_cnt == 4'd8) begin
          bit_cnt_n = '0;
          state_n = READ_ACK;
          sda_oe_n = 1'b0;
        end else begin
          sda_oe_n = ~tx_byte[~bit_cnt[2:0]];
        end
        READ_ACK: begin
          bit_cnt_n = '0;
          state_n = ack ? WAIT_STOP : READ;
          tx_done_n = ack;
          idx_n = ack ? idx : idx_next;
          sda_oe_n = ~ack & ~tx_next[7];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      idx <= '0;
      rw <= 1'b0;
      wr <= 1'b0;
      ack <= 1'b0;
      sda_oe <= 1'b0;
      data_out <= '0;
      byte_count <= '0;
      busy <= 1'b0;
      rx_done <= 1'b0;
      tx_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_p <= scl_s;
      sda_p <= sda_s;
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shift <= shift_n;
      idx <= idx_n;
      rw <= rw_n;
      wr <= wr_n;
      ack <= ack_n;
      sda_oe <= sda_oe_n;
      data_out <= data_out_n;
      byte_count <= byte_count_n;
      busy <= busy_n;
      rx_done <= rx_done_n;
      tx_done <= tx_done_n;
      overflow <= overflow_n;
    end
endmodule

// File: tb/tb_i2c_slave_param.sv
// tb_i2c_slave_param: randomized I2C master driving the slave, frame-level reference model, pulse scoreboard
`timescale 1ns/1ps
module tb_i2c_slave_param;
  localparam logic [6:0] ADDR = 7'h6A;
  localparam int NB = 4;
  localparam int TXN = 4;
  localparam int H = 4;
  typedef struct { bit is_tx; logic [31:0] d; int cnt; } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire sda;
  logic [8*TXN-1:0] data_in = '0;
  logic [8*NB-1:0] data_out;
  logic [2:0] byte_count;
  logic busy, rx_done, tx_done, overflow;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic [7:0] pl[$];
  logic [7:0] rx_m[$];
  logic [7:0] tx_bytes [TXN];
  bit mdl_wr = 1'b0, mdl_ovf = 1'b0;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  i2c_slave_param #(.ADDRESS(ADDR), .NBYTES(NB), .TX_NBYTES(TXN)) dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .sda(sda), .data_in(data_in),
    .data_out(data_out), .byte_count(byte_count), .busy(busy),
    .rx_done(rx_done), .tx_done(tx_done), .overflow(overflow)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [31:0] pack();
    logic [31:0] p;
    p = '0;
    foreach (rx_m[i]) p = (p << 8) | {24'd0, rx_m[i]};
    return p;
  endfunction
  task automatic load_tx();
    for (int i = 0; i < TXN; i++) data_in[8*(TXN-1-i) +: 8] = tx_bytes[i];
  endtask
  task automatic clk_bit(input logic b, output logic r);
    m_low = ~b;
    w(H);
    scl = 1'b1;
    w(H/2);
    r = sda;
    w(H - H/2);
    scl = 1'b0;
    w(H);
  endtask
  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(v[i], r);
    clk_bit(1'b1, ack);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic r;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      v = {v[6:0], r};
    end
    clk_bit(nack, r);
  endtask
  task automatic start_frame();
    m_low = 1'b0;
    w(H);
    scl = 1'b1;
    w(H);
    m_low = 1'b1;
    w(H);
    scl = 1'b0;
    w(H);
    rx_m.delete();
    mdl_wr = 1'b0;
    mdl_ovf = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("count_cleared", 64'(byte_count), 64'd0);
    check("data_cleared", 64'(data_out), 64'd0);
    check("overflow_cleared", 64'(overflow), 64'd0);
  endtask
  task automatic stop_frame();
    if (mdl_wr && rx_m.size() > 0) exp_q.push_back('{1'b0, pack(), rx_m.size()});
    m_low = 1'b1;
    w(H);
    scl = 1'b1;
    w(H);
    m_low = 1'b0;
    w(H + 2);
    check("busy_after_stop", 64'(busy), 64'd0);
  endtask
  task automatic write_frame(input logic [6:0] a, input bit do_stop);
    logic ak;
    bit accept;
    start_frame();
    send_byte({a, 1'b0}, ak);
    check("waddr_ack", 64'(ak), 64'(a != ADDR));
    mdl_wr = (a == ADDR);
    foreach (pl[k]) begin
      accept = mdl_wr && rx_m.size() < NB;
      send_byte(pl[k], ak);
      check("data_ack", 64'(ak), 64'(!accept));
      if (accept) rx_m.push_back(pl[k]);
      else if (mdl_wr) begin
        mdl_ovf = 1'b1;
        break;
      end
    end
    check("frame_count", 64'(byte_count), 64'(rx_m.size()));
    check("frame_data", 64'(data_out), 64'(pack()));
    check("frame_overflow", 64'(overflow), 64'(mdl_ovf));
    check("frame_busy", 64'(busy), 64'd1);
    if (do_stop) stop_frame();
  endtask
  task automatic read_frame(input logic [6:0] a, input int n);
    logic ak;
    logic [7:0] v;
    int idx;
    start_frame();
    send_byte({a, 1'b1}, ak);
    check("raddr_ack", 64'(ak), 64'(a != ADDR));
    idx = 0;
    if (a == ADDR) for (int k = 0; k < n; k++) begin
      if (k == n - 1) exp_q.push_back('{1'b1, 32'd0, 0});
      recv_byte(k == n - 1, v);
      check("read_byte", 64'(v), 64'(tx_bytes[idx]));
      idx = (idx + 1) % TXN;
    end
    stop_frame();
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (rx_done || tx_done)) begin
        if (exp_q.size() == 0) check("unexpected_pulse", 64'({tx_done, rx_done}), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("pulse_kind", 64'({tx_done, rx_done}), e.is_tx ? 64'd2 : 64'd1);
          if (!e.is_tx) begin
            check("rx_data", 64'(data_out), 64'(e.d));
            check("rx_count", 64'(byte_count), 64'(e.cnt));
          end
          @(negedge clk);
          check("pulse_width", 64'(rx_done | tx_done), 64'd0);
        end
      end
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end
  initial begin
    logic ak;
    logic [6:0] a;
    int n;
    foreach (tx_bytes[i]) tx_bytes[i] = 8'h00;
    load_tx();
    w(3);
    check("rst_sda", 64'(sda), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(byte_count), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_flags", 64'({rx_done, tx_done, overflow}), 64'd0);
    reset_n = 1'b1;
    w(2*H);
    pl = '{8'h11, 8'h22};
    write_frame(ADDR, 1'b1);
    check("two_byte_data", 64'(data_out[15:0]), 64'h1122);
    check("two_byte_count", 64'(byte_count), 64'd2);
    pl = '{8'h5A, 8'hFF};
    write_frame(7'h50, 1'b1);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    write_frame(ADDR, 1'b1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_data", 64'(data_out), 64'h01020304);
    check("ovf_count", 64'(byte_count), 64'd4);
    tx_bytes = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    load_tx();
    read_frame(ADDR, 2);
    tx_bytes = '{8'h81, 8'h7E, 8'hC3, 8'h18};
    load_tx();
    read_frame(ADDR, 6);
    pl = '{8'h55};
    write_frame(ADDR, 1'b0);
    read_frame(ADDR, 1);
    pl = '{8'h77};
    write_frame(ADDR, 1'b0);
    clk_bit(1'b1, ak);
    clk_bit(1'b0, ak);
    clk_bit(1'b1, ak);
    m_low = 1'b0;
    w(H);
    scl = 1'b1;
    w(2);
    reset_n = 1'b0;
    w(1);
    check("midrst_sda", 64'(sda), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_data", 64'(data_out), 64'd0);
    check("midrst_count", 64'(byte_count), 64'd0);
    check("midrst_flags", 64'({rx_done, tx_done, overflow}), 64'd0);
    rx_m.delete();
    mdl_wr = 1'b0;
    scl = 1'b0;
    w(H);
    reset_n = 1'b1;
    w(H);
    repeat (6) clk_bit(1'($urandom_range(0, 1)), ak);
    check("ignore_busy", 64'(busy), 64'd0);
    check("ignore_count", 64'(byte_count), 64'd0);
    stop_frame();
    for (int it = 0; it < 14; it++) begin
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : ADDR;
      if ($urandom_range(0, 1) == 1) begin
        pl.delete();
        n = $urandom_range(0, 6);
        repeat (n) pl.push_back(8'($urandom));
        write_frame(a, 1'b1);
      end else begin
        foreach (tx_bytes[i]) tx_bytes[i] = 8'($urandom);
        load_tx();
        read_frame(a, $urandom_range(1, 6));
      end
    end
    w(20);
    check("pending_expect", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
